// File: rtl/tt_sum_pkg.sv
// Shared types and helpers for the tt_sum accumulator slice: operation
// modes, default widths and the saturation clamp.
package tt_sum_pkg;

    typedef enum logic [1:0] {
        MODE_ADD = 2'b00,
        MODE_ACC = 2'b01,
        MODE_SAT = 2'b10,
        MODE_SUB = 2'b11
    } mode_e;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_ACC_WIDTH = 16;
    localparam int DEF_CNT_WIDTH = 8;

    // Clamp a wide sum to the largest value representable in w bits.
    function automatic logic [63:0] clamp_max(input logic [63:0] sum, input int w);
        logic [63:0] max_v;
        max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (sum > max_v) ? max_v : sum;
    endfunction

endpackage

// File: rtl/tt_sum_accumulator_if.sv
// Operand/result bundle for tt_sum_accumulator. The master drives operands
// and control; the slave (the accumulator) returns result and status.
interface tt_sum_accumulator_if import tt_sum_pkg::*; #(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
);
    logic                 ena;
    logic                 in_valid;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    mode_e                mode;
    logic                 clear;
    logic                 out_valid;
    logic [ACC_WIDTH-1:0] result;
    logic                 overflow;
    logic [CNT_WIDTH-1:0] sample_cnt;

    modport master (
        output ena, in_valid, a, b, mode, clear,
        input  out_valid, result, overflow, sample_cnt
    );

    modport slave (
        input  ena, in_valid, a, b, mode, clear,
        output out_valid, result, overflow, sample_cnt
    );
endinterface

// File: rtl/tt_sum_alu.sv
// Combinational datapath: computes the next result and its overflow bit
// for one operand pair under the selected mode. Operands are widened by
// one bit beyond ACC_WIDTH so the top bit is the carry/borrow.
module tt_sum_alu import tt_sum_pkg::*; #(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [ACC_WIDTH-1:0] acc,
    input  mode_e                mode,
    output logic [ACC_WIDTH-1:0] nxt,
    output logic                 ovf
);
    localparam int EW = ACC_WIDTH + 1;

    logic [EW-1:0]        a_x, b_x, acc_x;
    logic [EW-1:0]        sum_ab, sum_acc, diff;
    logic [ACC_WIDTH-1:0] sat_res;

    assign a_x     = EW'(a);
    assign b_x     = EW'(b);
    assign acc_x   = EW'(acc);
    assign sum_ab  = a_x + b_x;
    assign sum_acc = acc_x + a_x + b_x;
    assign diff    = a_x - b_x;
    assign sat_res = ACC_WIDTH'(clamp_max(64'(sum_ab), ACC_WIDTH));

    // Select result and carry/borrow for the requested operation.
    always_comb begin
        nxt = sum_ab[ACC_WIDTH-1:0];
        ovf = sum_ab[ACC_WIDTH];
        unique case (mode)
            MODE_ADD: begin
                nxt = sum_ab[ACC_WIDTH-1:0];
                ovf = sum_ab[ACC_WIDTH];
            end
            MODE_ACC: begin
                nxt = sum_acc[ACC_WIDTH-1:0];
                ovf = sum_acc[ACC_WIDTH];
            end
            MODE_SAT: begin
                nxt = sat_res;
                ovf = sum_ab[ACC_WIDTH];
            end
            MODE_SUB: begin
                nxt = diff[ACC_WIDTH-1:0];
                ovf = diff[ACC_WIDTH];
            end
        endcase
    end
endmodule

// File: rtl/tt_sum_accumulator.sv
// Registered two-operand adder/accumulator with sticky overflow and a
// saturating sample counter. Define TT_SUM_PIPE_EN to add a second
// register stage after the ALU (2-cycle latency); status outputs then
// update together with the delayed result. The accumulator itself always
// lives in stage 1 so back-to-back ACC samples chain without stalls.
module tt_sum_accumulator import tt_sum_pkg::*; #(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    tt_sum_accumulator_if.slave bus
);
`ifdef TT_SUM_PIPE_EN
    localparam int STAGES = 2;
`else
    localparam int STAGES = 1;
`endif
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                 accept, do_clear;
    logic                 commit, commit_ovf;
    logic [ACC_WIDTH-1:0] alu_nxt;
    logic                 alu_ovf;
    logic [ACC_WIDTH-1:0] acc_q, s1_res;
    logic [STAGES:1]      vld_pipe;
    logic                 ovf_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    // clear wins over a sample in the same cycle; ena=0 masks both.
    assign accept   = bus.ena && bus.in_valid && !bus.clear;
    assign do_clear = bus.ena && bus.clear;

    tt_sum_alu #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_alu (
        .a    (bus.a),
        .b    (bus.b),
        .acc  (acc_q),
        .mode (bus.mode),
        .nxt  (alu_nxt),
        .ovf  (alu_ovf)
    );

    // Valid shift register: bit 1 is stage 1, bit STAGES drives out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        vld_pipe <= '0;
        else if (do_clear) vld_pipe <= '0;
        else               vld_pipe <= STAGES'({vld_pipe, accept});
    end

    // Stage 1: capture ALU result; accumulator advances only in ACC mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            s1_res <= '0;
        end else if (do_clear) begin
            acc_q  <= '0;
            s1_res <= '0;
        end else if (accept) begin
            s1_res <= alu_nxt;
            if (bus.mode == MODE_ACC) acc_q <= alu_nxt;
        end
    end

`ifdef TT_SUM_PIPE_EN
    logic                 s1_ovf;
    logic [ACC_WIDTH-1:0] s2_res;

    // Stage 2: hold the result and carry the overflow bit alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_ovf <= 1'b0;
            s2_res <= '0;
        end else if (do_clear) begin
            s1_ovf <= 1'b0;
            s2_res <= '0;
        end else begin
            if (accept)      s1_ovf <= alu_ovf;
            if (vld_pipe[1]) s2_res <= s1_res;
        end
    end

    assign commit     = vld_pipe[1];
    assign commit_ovf = s1_ovf;
    assign bus.result = s2_res;
`else
    assign commit     = accept;
    assign commit_ovf = alu_ovf;
    assign bus.result = s1_res;
`endif

    // Status: sticky overflow and saturating count, aligned with result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else if (do_clear) begin
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else if (commit) begin
            ovf_q <= ovf_q | commit_ovf;
            if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    assign bus.out_valid  = vld_pipe[STAGES];
    assign bus.overflow   = ovf_q;
    assign bus.sample_cnt = cnt_q;
endmodule
